// File: rtl/pause_ctrl_multi_if.sv
// Signal bundle between an arcade core and the pause controller.
// master = core/video side driving requests and pixels, slave = the controller.
interface pause_ctrl_multi_if #(
    parameter int unsigned RW      = 3,
    parameter int unsigned GW      = 3,
    parameter int unsigned BW      = 2,
    parameter int unsigned NUM_REQ = 2
);
    localparam int unsigned CW = RW + GW + BW;

    logic               user_button;
    logic [NUM_REQ-1:0] pause_request;
    logic               OSD_STATUS;
    logic [1:0]         options;
    logic [CW-1:0]      RGB_in;
    logic [CW-1:0]      RGB_out;
    logic               pause_cpu;
    logic               dim_active;

    modport master (
        output user_button, pause_request, OSD_STATUS, options, RGB_in,
        input  RGB_out, pause_cpu, dim_active
    );

    modport slave (
        input  user_button, pause_request, OSD_STATUS, options, RGB_in,
        output RGB_out, pause_cpu, dim_active
    );
endinterface

// File: rtl/pause_ctrl_multi.sv
// Pause controller: merges user/OSD/request pause sources into a registered CPU pause
// and dims the RGB stream once the game has been paused for DIM_SEC seconds.
module pause_ctrl_multi #(
    parameter int unsigned       RW        = 3,
    parameter int unsigned       GW        = 3,
    parameter int unsigned       BW        = 2,
    parameter int unsigned       NUM_REQ   = 2,
    parameter logic [NUM_REQ-1:0] DIM_MASK = '1,
    parameter int unsigned       CLK_HZ    = 12000000,
    parameter int unsigned       DIM_SEC   = 10,
    parameter int unsigned       DIM_SHIFT = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    pause_ctrl_multi_if.slave    bus
);
    localparam int unsigned CW = RW + GW + BW;
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [7:0]    SEC_MAX = 8'(DIM_SEC);

    typedef enum logic [1:0] {StRun, StPaused, StDimmed} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [7:0]      sec_q, sec_d;
    logic            btn_q, user_pause_q;
    logic            pause_cpu_q, dim_q;
    logic [CW-1:0]   rgb_q, rgb_d;

    logic            pause_any, dim_src;
    logic [7:0]      sec_inc;
    logic [RW-1:0]   r_in;
    logic [GW-1:0]   g_in;
    logic [BW-1:0]   b_in;

    assign pause_any = user_pause_q | (|bus.pause_request) | (bus.OSD_STATUS & bus.options[0]);
    assign dim_src   = user_pause_q | (|(bus.pause_request & DIM_MASK))
                     | (bus.OSD_STATUS & bus.options[0]);
    assign sec_inc   = (sec_q < SEC_MAX) ? sec_q + 8'd1 : sec_q;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sec_d   = sec_q;
        unique case (state_q)
            StRun: begin
                if (pause_any) begin
                    state_d = StPaused;
                    pre_d   = '0;
                    sec_d   = '0;
                end
            end
            StPaused: begin
                // Unpause is checked first so it beats a simultaneous final wrap.
                if (!pause_any) begin
                    state_d = StRun;
                end else if (dim_src && bus.options[1]) begin
                    if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        sec_d = sec_inc;
                        if (sec_inc == SEC_MAX) state_d = StDimmed;
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end else begin
                    pre_d = '0;
                    sec_d = '0;
                end
            end
            StDimmed: begin
                if (!pause_any) begin
                    state_d = StRun;
                    pre_d   = '0;
                    sec_d   = '0;
                end else if (!bus.options[1] || !dim_src) begin
                    state_d = StPaused;
                    pre_d   = '0;
                    sec_d   = '0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    assign r_in = bus.RGB_in[CW-1 -: RW];
    assign g_in = bus.RGB_in[BW +: GW];
    assign b_in = bus.RGB_in[BW-1:0];

    always_comb begin
        rgb_d = bus.RGB_in;
        if (state_d == StDimmed) begin
            rgb_d = {r_in - (r_in >> DIM_SHIFT),
                     g_in - (g_in >> DIM_SHIFT),
                     b_in - (b_in >> DIM_SHIFT)};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            pre_q        <= '0;
            sec_q        <= '0;
            btn_q        <= 1'b0;
            user_pause_q <= 1'b0;
            pause_cpu_q  <= 1'b0;
            dim_q        <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            sec_q        <= sec_d;
            btn_q        <= bus.user_button;
            if (bus.user_button && !btn_q) user_pause_q <= ~user_pause_q;
            pause_cpu_q  <= pause_any;
            dim_q        <= (state_d == StDimmed);
            rgb_q        <= rgb_d;
        end
    end

    assign bus.RGB_out    = rgb_q;
    assign bus.pause_cpu  = pause_cpu_q;
    assign bus.dim_active = dim_q;
endmodule

// File: doc/pause_ctrl_multi.md
Name: pause_ctrl_multi

Overview:
- Parametrised pause controller for arcade cores. Sits between the core's video output and arcade_video, and drives the core's pause input.
- Merges a user pause toggle, an OSD-open pause and NUM_REQ independent pause-request channels (hiscore save, debugger, etc.) into one registered CPU pause.
- After a programmable idle time it dims the RGB stream.
- Generalises the fixed 3/3/2 single-request pause to arbitrary colour widths, N request channels, a per-channel dim mask and a configurable dim depth.

Parameters:
RW, 3, red channel width in bits
GW, 3, green channel width in bits
BW, 2, blue channel width in bits
NUM_REQ, 2, number of external pause-request channels (1..8)
DIM_MASK, all ones, bit i=1: request channel i may start the dim timer
CLK_HZ, 12000000, clk_sys frequency in Hz, sets the 1 s prescaler
DIM_SEC, 10, seconds paused before dimming (1..255)
DIM_SHIFT, 1, dim attenuation: out = in - (in >> DIM_SHIFT) (1..3)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
user_button  in  1  user pause button, level, toggles on rising edge
pause_request  in  NUM_REQ  external pause requests, level, active high
OSD_STATUS  in  1  OSD open, level
options  in  2  [0] pause when OSD open enable; [1] dim enable
RGB_in  in  RW+GW+BW  {R,G,B} from core
RGB_out  out  RW+GW+BW  {R,G,B} to video pipeline, registered
pause_cpu  out  1  registered CPU pause
dim_active  out  1  dimming currently applied

Behaviour:
- Reset (reset_n=0, async): user_pause=0, button edge register=0, prescaler=0, sec_cnt=0, state=RUN, pause_cpu=0, dim_active=0, RGB_out=0.
- Edge detect: btn_q <= user_button. A rise is user_button & ~btn_q. Each rise toggles user_pause, including while other sources are active.
- Pause sources:
  - pause_any = user_pause | (|pause_request) | (OSD_STATUS & options[0]).
  - pause_cpu <= pause_any, giving 1-cycle latency from any request level (2 cycles from the button edge).
- Dim eligibility: dim_src = user_pause | (|(pause_request & DIM_MASK)) | (OSD_STATUS & options[0]).
- State machine:
  - RUN: pause_any=1 -> PAUSED, with prescaler and sec_cnt cleared.
  - PAUSED:
    - pause_any=0 -> RUN.
    - Otherwise, if dim_src & options[1]: prescaler counts 0..CLK_HZ-1. On wrap, sec_cnt increments, saturating at DIM_SEC. When sec_cnt reaches DIM_SEC -> DIMMED.
    - If dim_src or options[1] drops, prescaler and sec_cnt clear and the state stays PAUSED.
  - DIMMED:
    - pause_any=0 -> RUN, counters cleared.
    - options[1]=0 or dim_src=0 -> PAUSED, counters cleared.
- dim_active is a registered output, 1 exactly while state==DIMMED.
- Video path:
  - Each channel is processed independently: c_out = c - (c >> DIM_SHIFT) when DIMMED, else c. Unsigned, width preserved, no overflow possible.
  - RGB_out is registered, 1-cycle latency, updated every clk_sys cycle; no pixel enable is required.
- Boundaries:
  - Unpause in the same cycle that the prescaler wraps to DIM_SEC: the unpause wins and the state goes to RUN.
  - A button rise while already paused by a request turns on user_pause. Pause persists until every source is released.
  - Reset mid-DIMMED: RGB_out=0 and dim_active=0 immediately (async). After release the block restarts in RUN.
  - All-zero RGB_in stays 0 when dimmed. Max value 7 with DIM_SHIFT=1 gives 4.
- Counter widths:
  - prescaler is $clog2(CLK_HZ) bits.
  - sec_cnt is 8 bits.

Test Plan:
- Reset/passthrough: hold reset_n=0, then release with RGB_in=8'hB6 and no requests -> RGB_out=8'h00 during reset; RGB_out=8'hB6 one cycle after release; pause_cpu=0.
- User toggle: pulse user_button 1 cycle -> pause_cpu=1 two cycles later. A second pulse -> pause_cpu=0 two cycles later. Holding the button high for 100 cycles toggles only once.
- Dim timing (CLK_HZ=100, DIM_SEC=3, options=2'b11): user pause, RGB_in=8'hFF -> dim_active=1 after 300 (±2) cycles. RGB_out={3'd4,3'd4,2'd2}=8'h92. Unpause -> RGB_out=8'hFF and dim_active=0 within 2 cycles.
- Dim mask (NUM_REQ=2, DIM_MASK=2'b10): hold pause_request=2'b01 for 1000 cycles -> pause_cpu=1, dim_active stays 0. Switch to 2'b10 -> dim after 300 cycles.
- OSD option: OSD_STATUS=1 with options[0]=0 -> pause_cpu=0. Set options[0]=1 -> pause_cpu=1 next cycle. Clear options[1] while DIMMED -> dim_active=0 and undimmed RGB next cycle, pause_cpu still 1.
- Async reset mid-dim: assert reset_n=0 while DIMMED, between clock edges -> RGB_out, pause_cpu and dim_active go to 0 without waiting for a clock edge. After release, the first pause restarts a full 300-cycle timer.
